// File: rtl/ring_scan_stream.sv
// ring_scan_stream: pops scan_len ring entries and streams them as {index,data} words with backpressure.
// Optional max-data tracker (peak_*_o) is built when RING_SCAN_PEAK_EN is defined.
module ring_scan_stream #(
  parameter int DATA_W = 14,
  parameter int IDX_W  = 7,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        scan_len_i,
  input  logic [DATA_W-1:0]       ring_dout_i,
  input  logic [IDX_W-1:0]        ring_index_i,
  input  logic                    ring_ready_i,
  output logic                    ring_rd_en_o,
  output logic [IDX_W+DATA_W-1:0] m_tdata_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic                    m_tlast_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef RING_SCAN_PEAK_EN
  ,
  output logic [DATA_W-1:0]       peak_data_o,
  output logic [IDX_W-1:0]        peak_index_o,
  output logic                    peak_valid_o
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, OUT, DONE} state_t;
  state_t                    state_q;
  logic [LEN_W-1:0]          cnt_q, len_q;
  logic [IDX_W+DATA_W-1:0]   tdata_q;
  logic                      tvalid_q, tlast_q, busy_q, done_q;
  assign ring_rd_en_o = (state_q == FETCH) && ring_ready_i;
  assign m_tdata_o    = tdata_q;
  assign m_tvalid_o   = tvalid_q;
  assign m_tlast_o    = tlast_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          len_q   <= scan_len_i;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= scan_len_i == '0;
          state_q <= scan_len_i == '0 ? DONE : FETCH;
        end
        FETCH: if (ring_ready_i) begin
          tdata_q  <= {ring_index_i, ring_dout_i};
          tlast_q  <= cnt_q == len_q - 1'b1;
          tvalid_q <= 1'b1;
          state_q  <= OUT;
        end
        OUT: if (m_tready_i) begin
          tvalid_q <= 1'b0;
          cnt_q    <= cnt_q + 1'b1;
          done_q   <= tlast_q;
          state_q  <= tlast_q ? DONE : FETCH;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
`ifdef RING_SCAN_PEAK_EN
  logic [DATA_W-1:0] pk_data_q;
  logic [IDX_W-1:0]  pk_idx_q;
  logic              pk_valid_q;
  assign peak_data_o  = pk_data_q;
  assign peak_index_o = pk_idx_q;
  assign peak_valid_o = pk_valid_q;
  // strict > keeps the earliest word on ties; the first capture always loads
  always_ff @(posedge clk) begin
    if (rst) begin
      pk_data_q  <= '0;
      pk_idx_q   <= '0;
      pk_valid_q <= 1'b0;
    end else begin
      pk_valid_q <= 1'b0;
      if (state_q == IDLE && start_i) begin
        pk_data_q  <= '0;
        pk_idx_q   <= '0;
        pk_valid_q <= scan_len_i == '0;
      end else if (ring_rd_en_o && (cnt_q == '0 || ring_dout_i > pk_data_q)) begin
        pk_data_q <= ring_dout_i;
        pk_idx_q  <= ring_index_i;
      end else if (state_q == OUT && m_tready_i && tlast_q) begin
        pk_valid_q <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_ring_scan_stream.sv
// tb_ring_scan_stream: randomized scoreboard bench for ring_scan_stream against a ring model.
module tb_ring_scan_stream;
  localparam int DATA_W = 14, IDX_W = 7, LEN_W = 8, TW = IDX_W + DATA_W;
  logic clk = 0, rst = 1, start = 0;
  logic [LEN_W-1:0] scan_len = '0;
  logic [DATA_W-1:0] ring_dout;
  logic [IDX_W-1:0] ring_index;
  logic ring_ready = 0, ring_rd_en, m_tready = 0;
  logic [TW-1:0] m_tdata;
  logic m_tvalid, m_tlast, busy, done;
`ifdef RING_SCAN_PEAK_EN
  logic [DATA_W-1:0] peak_data;
  logic [IDX_W-1:0] peak_index;
  logic peak_valid;
`endif
  ring_scan_stream dut (
    .clk(clk), .rst(rst), .start_i(start), .scan_len_i(scan_len),
    .ring_dout_i(ring_dout), .ring_index_i(ring_index), .ring_ready_i(ring_ready),
    .ring_rd_en_o(ring_rd_en), .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid),
    .m_tready_i(m_tready), .m_tlast_o(m_tlast), .busy_o(busy), .done_o(done)
`ifdef RING_SCAN_PEAK_EN
    , .peak_data_o(peak_data), .peak_index_o(peak_index), .peak_valid_o(peak_valid)
`endif
  );
  always #5 clk = ~clk;

  // ring model: head advances on every pop; index is the head pointer itself
  logic [DATA_W-1:0] mem [128];
  logic [IDX_W-1:0] head = '0, head_set = '0;
  logic head_load = 0;
  assign ring_dout  = mem[head];
  assign ring_index = head;
  always @(posedge clk) head <= head_load ? head_set : ring_rd_en ? head + 1'b1 : head;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [TW:0] q[$];
  logic [DATA_W-1:0] exp_pk_d;
  logic [IDX_W-1:0] exp_pk_i;
  int words = 0, rds = 0, dones = 0;
  longint cyc = 0, last_cyc = -100, done_cyc = -100;
  logic [TW-1:0] prev_d;
  logic prev_l, prev_stall = 0;
  bit rnd = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (ring_rd_en) begin
        rds++;
        chk("rd_en_needs_ready", ring_ready, 1);
        chk("rd_en_while_valid", m_tvalid, 0);
      end
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, prev_d);
        chk("hold_last", m_tlast, prev_l);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      if (m_tvalid && m_tready) begin
        words++;
        chk("word_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          logic [TW:0] e;
          e = q.pop_front();
          chk("tdata", m_tdata, e[TW-1:0]);
          chk("tlast", m_tlast, e[TW]);
        end
        if (m_tlast) last_cyc = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
`ifdef RING_SCAN_PEAK_EN
        chk("peak_valid", peak_valid, 1);
        chk("peak_data", peak_data, exp_pk_d);
        chk("peak_index", peak_index, exp_pk_i);
`endif
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) begin
      ring_ready = $urandom_range(0, 3) != 0;
      m_tready   = $urandom_range(0, 2) != 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_head(input logic [IDX_W-1:0] h);
    head_set = h; head_load = 1; tick(); head_load = 0;
  endtask

  task automatic issue(input int len, input bit dup = 0);
    exp_pk_d = '0; exp_pk_i = '0;
    for (int k = 0; k < len; k++) begin
      logic [IDX_W-1:0] ix;
      ix = head + IDX_W'(k);
      q.push_back({k == len - 1, ix, mem[ix]});
      if (k == 0 || mem[ix] > exp_pk_d) begin exp_pk_d = mem[ix]; exp_pk_i = ix; end
    end
    start = 1; scan_len = LEN_W'(len); tick(); start = 0;
    if (dup) begin
      tick(3);
      start = 1; scan_len = 8'd5; tick(); start = 0;
    end
  endtask

  task automatic run(input int len, input bit dup = 0);
    int w0, r0, d0, t;
    w0 = words; r0 = rds; d0 = dones; t = 0;
    issue(len, dup);
    while (dones == d0 && t < 5000) begin tick(); t++; end
    chk("done_seen", dones - d0, 1);
    chk("word_count", words - w0, len);
    chk("rd_en_count", rds - r0, len);
    chk("queue_empty", q.size(), 0);
    if (len > 0) chk("done_latency", done_cyc - last_cyc, 1);
    chk("busy_after_done", busy, 0);
    tick(2);
    chk("single_done", dones - d0, 1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!m_tvalid && t < 200) begin tick(); t++; end
    chk("valid_seen", m_tvalid, 1);
  endtask

  initial begin
    int w0, t, d0;
    for (int i = 0; i < 128; i++) mem[i] = DATA_W'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = DATA_W'(100 + i);
    tick(3);
    chk("rst_rd_en", ring_rd_en, 0); chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);    chk("rst_tdata", m_tdata, 0);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    rst = 0;
    load_head(0);
    ring_ready = 1; m_tready = 1;
    run(3);
    // backpressure: first word held for 5 cycles
    m_tready = 0;
    w0 = words;
    fork run(2); begin wait_valid(); tick(5); m_tready = 1; end join
    // ring stall mid-scan
    w0 = words;
    fork
      run(4);
      begin
        t = 0;
        while (words - w0 < 2 && t < 200) begin tick(); t++; end
        ring_ready = 0;
        for (int i = 0; i < 10; i++) begin
          tick();
          chk("stall_rd_en", ring_rd_en, 0);
          chk("stall_tvalid", m_tvalid, 0);
        end
        ring_ready = 1;
      end
    join
    // wrap and full length
    load_head(7'd125);
    rnd = 1;
    run(128);
    run(0);
    run(6, 1);
    for (int i = 0; i < 8; i++) run($urandom_range(1, 20));
    // reset mid-scan while a word is held
    rnd = 0; tick(); ring_ready = 1; m_tready = 0;
    start = 1; scan_len = 8'd10; tick(); start = 0;
    wait_valid();
    rst = 1; tick(); rst = 0;
    q.delete();
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_busy", busy, 0);
    d0 = dones;
    tick(5);
    chk("rst_mid_no_done", dones - d0, 0);
    // peak pattern: tie goes to the first 900
    m_tready = 1;
    mem[head] = 5; mem[head + 7'd1] = 900; mem[head + 7'd2] = 900; mem[head + 7'd3] = 7;
    run(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ring_scan_stream.md
Name: ring_scan_stream

Overview:
- Downstream consumer of the 128-entry tone ring buffer.
- On a start pulse, pops scan_len consecutive entries through the ring's ready/rd_en interface.
- Tags each entry with its ring index and presents it on an AXI-Stream-style master port with backpressure.
- Feeds the frequency-selector readout / DMA path; one scan produces one framed packet terminated by m_tlast.

Parameters:
- DATA_W, 14, width of ring data word
- IDX_W, 7, width of ring index; ring depth 2**IDX_W
- LEN_W, 8, width of scan_len (IDX_W+1, allows full 128-entry scan)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse: begin a scan; ignored while busy=1
- scan_len  in  LEN_W  entries to read; sampled on accepted start
- ring_dout  in  DATA_W  head-of-ring data word
- ring_index  in  IDX_W  ring index of ring_dout
- ring_ready  in  1  ring head word valid and poppable
- ring_rd_en  out  1  pop strobe to ring, one cycle per word
- m_tdata  out  IDX_W+DATA_W  {index, data}; index in MSBs
- m_tvalid  out  1  output word valid
- m_tready  in  1  downstream accepts
- m_tlast  out  1  final word of scan
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion

Behaviour:
- Reset values:
  - ring_rd_en=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0.
  - State=IDLE, word counter=0, latched length=0.
- States: IDLE, FETCH, OUT, DONE.
- IDLE:
  - busy=0.
  - start=1 with scan_len!=0: latch scan_len, clear counter, go FETCH, busy=1 next cycle.
  - start=1 with scan_len==0: go DONE directly; no words emitted, no rd_en.
- FETCH:
  - Waits indefinitely while ring_ready=0; no timeout.
  - When ring_ready=1 in the same cycle: ring_rd_en=1 (combinational, only in this cycle), and register m_tdata<={ring_index, ring_dout}.
  - Set m_tlast<=(counter==len-1) and m_tvalid<=1, then go OUT.
- OUT:
  - m_tvalid=1; m_tdata/m_tlast held stable while m_tready=0.
  - On m_tvalid&m_tready: m_tvalid<=0 and counter<=counter+1.
  - If m_tlast, go DONE; else go FETCH.
  - ring_rd_en=0 throughout, so the ring's buf_0 update has settled before the next capture.
- DONE:
  - One cycle; done=1, busy=0 on the following cycle, then return to IDLE.
  - A start in the DONE cycle is ignored.
- Throughput: at most one word per 2 cycles (FETCH+OUT). Latency from ring_ready in FETCH to m_tvalid is 1 cycle.
- rd_en rule: at most one rd_en per emitted word; never asserted while ring_ready=0 or outside FETCH.
- Counter width is LEN_W. scan_len=128 emits exactly 128 words. Index wrap (127->0) is passed through unmodified from ring_index.
- ring_ready dropping during OUT (ring refresh) has no effect on the held output word; FETCH then waits for ready again.
- rst mid-scan: all outputs return to reset values on the next edge. The in-flight word is dropped and no done pulse is generated.

Optional Feature:
- Macro: RING_SCAN_PEAK_EN.
- Defined:
  - Adds outputs peak_data (DATA_W), peak_index (IDX_W) and peak_valid (1).
  - Tracks the maximum unsigned data value over the scan words, updated at each FETCH capture.
  - Ties resolve to the earliest word.
  - peak_data/peak_index are valid, with peak_valid=1, in the DONE cycle.
  - Cleared to 0 on accepted start and on rst.
  - scan_len==0 gives peak_valid=1 with peak_data=0, peak_index=0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic scan: ring holds data 100..104 at indices 0..4, ring_ready=1, m_tready=1, start with scan_len=3 -> 3 words {0,100},{1,101},{2,102}, each on its own 2-cycle slot; m_tlast only on {2,102}; exactly 3 rd_en pulses; done one cycle after the last handshake.
- Backpressure: scan_len=2, m_tready=0 for 5 cycles after the first m_tvalid -> m_tdata held constant for those cycles; no second rd_en until the first word is accepted.
- Ring stall: ring_ready=0 for 10 cycles mid-scan -> ring_rd_en stays 0 and m_tvalid stays 0; the scan resumes with the correct next index once ready returns.
- Wrap and full length: ring_index sequence 125,126,127,0,... with scan_len=128 -> 128 words emitted; m_tlast on word 128; index passes 127 to 0 unmodified.
- Edge starts:
  - scan_len=0 -> done pulse, zero words, zero rd_en.
  - start while busy -> ignored; the word count still matches the first scan_len.
- Reset mid-scan, plus peak check (with RING_SCAN_PEAK_EN):
  - rst during OUT -> m_tvalid=0 next cycle, no done pulse.
  - Data 5,900,900,7 -> peak_data=900, peak_index = index of the first 900.
